// File: rtl/pipelined_controller.sv
// Main control unit for the 5-stage MIPS pipeline: decodes the ID-stage word and
// carries the control fields through ID/EX, EX/MEM and a MEM_STAGES-deep MEM/WB chain.
module pipelined_controller #(
    parameter int ALUCTL_W   = 4,
    parameter int MEM_STAGES = 1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [31:0]         Instruction,
    input  logic                Stall,
    input  logic                Flush,
    output logic                EX_Valid,
    output logic                EX_ALUSrc,
    output logic                EX_RegDst,
    output logic                EX_Link,
    output logic [ALUCTL_W-1:0] EX_ALUControl,
    output logic                EX_Illegal,
    output logic                MEM_Valid,
    output logic                MEM_MemRead,
    output logic                MEM_MemWrite,
    output logic                MEM_Branch,
    output logic                MEM_BranchNe,
    output logic                MEM_Jump,
    output logic                WB_Valid,
    output logic                WB_RegWrite,
    output logic                WB_MemToReg
);

    localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(0);
    localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(1);
    localparam logic [ALUCTL_W-1:0] ALU_AND = ALUCTL_W'(2);
    localparam logic [ALUCTL_W-1:0] ALU_OR  = ALUCTL_W'(3);
    localparam logic [ALUCTL_W-1:0] ALU_SLT = ALUCTL_W'(4);
    localparam logic [ALUCTL_W-1:0] ALU_SLL = ALUCTL_W'(5);
    localparam logic [ALUCTL_W-1:0] ALU_MUL = ALUCTL_W'(6);

    typedef struct packed {
        logic                valid;
        logic                illegal;
        logic                alu_src;
        logic                reg_dst;
        logic                link;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
        logic                branch_ne;
        logic                jump;
        logic                reg_write;
        logic                mem_to_reg;
        logic [ALUCTL_W-1:0] alu_ctl;
    } ex_ctl_t;

    typedef struct packed {
        logic valid;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic branch_ne;
        logic jump;
        logic reg_write;
        logic mem_to_reg;
    } mem_ctl_t;

    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
    } wb_ctl_t;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       legal;
    ex_ctl_t    dec;
    ex_ctl_t    ex_q;
    mem_ctl_t   mem_q;
    wb_ctl_t    wb_in;
    wb_ctl_t [MEM_STAGES-1:0] wb_q;
    wb_ctl_t [MEM_STAGES:0]   wb_pipe;

    assign opcode = Instruction[31:26];
    assign funct  = Instruction[5:0];

    always_comb begin
        dec   = '0;
        legal = 1'b1;
        case (opcode)
            6'b000000: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                case (funct)
                    6'b100000: dec.alu_ctl = ALU_ADD;
                    6'b100010: dec.alu_ctl = ALU_SUB;
                    6'b100100: dec.alu_ctl = ALU_AND;
                    6'b100101: dec.alu_ctl = ALU_OR;
                    6'b101010: dec.alu_ctl = ALU_SLT;
                    6'b000000: dec.alu_ctl = ALU_SLL;
                    default:   legal       = 1'b0;
                endcase
            end
            6'b011100: begin
                dec.reg_dst   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_ctl   = ALU_MUL;
                legal         = (funct == 6'b000010);
            end
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                case (opcode)
                    6'b001100: dec.alu_ctl = ALU_AND;
                    6'b001101: dec.alu_ctl = ALU_OR;
                    6'b001010: dec.alu_ctl = ALU_SLT;
                    default:   dec.alu_ctl = ALU_ADD;
                endcase
            end
            6'b100011: begin
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
            end
            6'b101011: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
            end
            6'b000100: begin
                dec.alu_ctl = ALU_SUB;
                dec.branch  = 1'b1;
            end
            6'b000101: begin
                dec.alu_ctl   = ALU_SUB;
                dec.branch    = 1'b1;
                dec.branch_ne = 1'b1;
            end
            6'b000010: dec.jump = 1'b1;
            6'b000011: begin
                dec.jump      = 1'b1;
                dec.link      = 1'b1;
                dec.reg_write = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        // All-zero word is the canonical NOP, not an sll, and must not flag illegal.
        if (Instruction == 32'h0) begin
            dec = '0;
        end else if (!legal) begin
            dec         = '0;
            dec.illegal = 1'b1;
        end else begin
            dec.valid = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || Flush || Stall) ex_q <= '0;
        else                       ex_q <= dec;
    end

    always_ff @(posedge Clk) begin
        if (Rst || Flush) begin
            mem_q <= '0;
        end else begin
            mem_q.valid      <= ex_q.valid;
            mem_q.mem_read   <= ex_q.mem_read;
            mem_q.mem_write  <= ex_q.mem_write;
            mem_q.branch     <= ex_q.branch;
            mem_q.branch_ne  <= ex_q.branch_ne;
            mem_q.jump       <= ex_q.jump;
            mem_q.reg_write  <= ex_q.reg_write;
            mem_q.mem_to_reg <= ex_q.mem_to_reg;
        end
    end

    // Only write-back fields ride the MEM chain; wb_pipe[0] is the EX/MEM tap.
    assign wb_in.valid      = mem_q.valid;
    assign wb_in.reg_write  = mem_q.reg_write;
    assign wb_in.mem_to_reg = mem_q.mem_to_reg;
    assign wb_pipe          = {wb_q, wb_in};

    always_ff @(posedge Clk) begin
        if (Rst) wb_q <= '0;
        else     wb_q <= wb_pipe[MEM_STAGES-1:0];
    end

    assign EX_Valid      = ex_q.valid;
    assign EX_ALUSrc     = ex_q.alu_src;
    assign EX_RegDst     = ex_q.reg_dst;
    assign EX_Link       = ex_q.link;
    assign EX_ALUControl = ex_q.alu_ctl;
    assign EX_Illegal    = ex_q.illegal;
    assign MEM_Valid     = mem_q.valid;
    assign MEM_MemRead   = mem_q.mem_read;
    assign MEM_MemWrite  = mem_q.mem_write;
    assign MEM_Branch    = mem_q.branch;
    assign MEM_BranchNe  = mem_q.branch_ne;
    assign MEM_Jump      = mem_q.jump;
    assign WB_Valid      = wb_pipe[MEM_STAGES].valid;
    assign WB_RegWrite   = wb_pipe[MEM_STAGES].reg_write;
    assign WB_MemToReg   = wb_pipe[MEM_STAGES].mem_to_reg;

endmodule

// File: tb/tb_pipelined_controller.sv
// Bench for pipelined_controller: a shallow (W=4, D=1) and a deep (W=6, D=3) instance
// share one stimulus stream and are checked against a slot-history reference model.
module tb_pipelined_controller;

    localparam logic [31:0] ADD    = 32'h01095020;
    localparam logic [31:0] SUB    = 32'h01095022;
    localparam logic [31:0] LW     = 32'h8C080004;
    localparam logic [31:0] SW     = 32'hAC080004;
    localparam logic [31:0] BEQ    = 32'h11090002;
    localparam logic [31:0] BNE    = 32'h15090002;
    localparam logic [31:0] ADDI   = 32'h21080005;
    localparam logic [31:0] JAL    = 32'h0C000010;
    localparam logic [31:0] ILL_OP = 32'hFC000000;
    localparam logic [31:0] ILL_FN = 32'h01095021;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Stall = 1'b0;
    logic        Flush = 1'b0;
    logic [31:0] Instruction = 32'h0;

    always #5 Clk = ~Clk;

    int asserts = 0;
    int fails = 0;

    logic       a_ex_valid, a_ex_alusrc, a_ex_regdst, a_ex_link, a_ex_ill;
    logic [3:0] a_ex_alu;
    logic       a_mem_valid, a_mem_rd, a_mem_wr, a_mem_br, a_mem_bne, a_mem_j;
    logic       a_wb_valid, a_wb_rw, a_wb_m2r;
    logic       b_ex_valid, b_ex_alusrc, b_ex_regdst, b_ex_link, b_ex_ill;
    logic [5:0] b_ex_alu;
    logic       b_mem_valid, b_mem_rd, b_mem_wr, b_mem_br, b_mem_bne, b_mem_j;
    logic       b_wb_valid, b_wb_rw, b_wb_m2r;

    pipelined_controller #(.ALUCTL_W(4), .MEM_STAGES(1)) dut_a (
        .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .Stall(Stall), .Flush(Flush),
        .EX_Valid(a_ex_valid), .EX_ALUSrc(a_ex_alusrc), .EX_RegDst(a_ex_regdst),
        .EX_Link(a_ex_link), .EX_ALUControl(a_ex_alu), .EX_Illegal(a_ex_ill),
        .MEM_Valid(a_mem_valid), .MEM_MemRead(a_mem_rd), .MEM_MemWrite(a_mem_wr),
        .MEM_Branch(a_mem_br), .MEM_BranchNe(a_mem_bne), .MEM_Jump(a_mem_j),
        .WB_Valid(a_wb_valid), .WB_RegWrite(a_wb_rw), .WB_MemToReg(a_wb_m2r)
    );

    pipelined_controller #(.ALUCTL_W(6), .MEM_STAGES(3)) dut_b (
        .Clk(Clk), .Rst(Rst), .Instruction(Instruction), .Stall(Stall), .Flush(Flush),
        .EX_Valid(b_ex_valid), .EX_ALUSrc(b_ex_alusrc), .EX_RegDst(b_ex_regdst),
        .EX_Link(b_ex_link), .EX_ALUControl(b_ex_alu), .EX_Illegal(b_ex_ill),
        .MEM_Valid(b_mem_valid), .MEM_MemRead(b_mem_rd), .MEM_MemWrite(b_mem_wr),
        .MEM_Branch(b_mem_br), .MEM_BranchNe(b_mem_bne), .MEM_Jump(b_mem_j),
        .WB_Valid(b_wb_valid), .WB_RegWrite(b_wb_rw), .WB_MemToReg(b_wb_m2r)
    );

    // Reference model: what occupies EX and MEM after each edge, plus where resets fell.
    typedef struct {
        bit valid, illegal, alu_src, reg_dst, link, mem_read, mem_write;
        bit branch, branch_ne, jump, reg_write, mem_to_reg;
        int alu;
    } slot_t;

    slot_t ex_m [0:4095];
    slot_t mem_m[0:4095];
    bit    rst_m[0:4095];
    int    cyc = -1;

    function automatic slot_t bubble();
        slot_t e = '{default: 0};
        return e;
    endfunction

    function automatic slot_t decode(logic [31:0] ins);
        slot_t e = '{default: 0};
        bit ok = 1;
        if (ins == 32'h0) return e;
        case (ins[31:26])
            6'd0: begin
                e.reg_dst = 1; e.reg_write = 1;
                case (ins[5:0])
                    6'd32: e.alu = 0;
                    6'd34: e.alu = 1;
                    6'd36: e.alu = 2;
                    6'd37: e.alu = 3;
                    6'd42: e.alu = 4;
                    6'd0:  e.alu = 5;
                    default: ok = 0;
                endcase
            end
            6'd28: if (ins[5:0] == 6'd2) begin e.alu = 6; e.reg_dst = 1; e.reg_write = 1; end
                   else ok = 0;
            6'd8:  begin e.alu = 0; e.alu_src = 1; e.reg_write = 1; end
            6'd12: begin e.alu = 2; e.alu_src = 1; e.reg_write = 1; end
            6'd13: begin e.alu = 3; e.alu_src = 1; e.reg_write = 1; end
            6'd10: begin e.alu = 4; e.alu_src = 1; e.reg_write = 1; end
            6'd35: begin e.alu_src = 1; e.mem_read = 1; e.mem_to_reg = 1; e.reg_write = 1; end
            6'd43: begin e.alu_src = 1; e.mem_write = 1; end
            6'd4:  begin e.alu = 1; e.branch = 1; end
            6'd5:  begin e.alu = 1; e.branch = 1; e.branch_ne = 1; end
            6'd2:  e.jump = 1;
            6'd3:  begin e.jump = 1; e.link = 1; e.reg_write = 1; end
            default: ok = 0;
        endcase
        if (!ok) begin e = '{default: 0}; e.illegal = 1; end
        else e.valid = 1;
        return e;
    endfunction

    // A MEM slot reaches WB d edges later unless a reset lands anywhere in between.
    function automatic slot_t wb_exp(int d);
        for (int j = cyc - d + 1; j <= cyc; j++)
            if (j >= 0 && rst_m[j]) return bubble();
        if (cyc - d < 0) return bubble();
        return mem_m[cyc - d];
    endfunction

    function automatic logic [21:0] model_vec(int d);
        slot_t e = ex_m[cyc];
        slot_t m = mem_m[cyc];
        slot_t w = wb_exp(d);
        return {e.valid, e.alu_src, e.reg_dst, e.link, e.illegal, 8'(e.alu),
                m.valid, m.mem_read, m.mem_write, m.branch, m.branch_ne, m.jump,
                w.valid, w.reg_write, w.mem_to_reg};
    endfunction

    function automatic logic [21:0] obs_a();
        return {a_ex_valid, a_ex_alusrc, a_ex_regdst, a_ex_link, a_ex_ill, 8'(a_ex_alu),
                a_mem_valid, a_mem_rd, a_mem_wr, a_mem_br, a_mem_bne, a_mem_j,
                a_wb_valid, a_wb_rw, a_wb_m2r};
    endfunction

    function automatic logic [21:0] obs_b();
        return {b_ex_valid, b_ex_alusrc, b_ex_regdst, b_ex_link, b_ex_ill, 8'(b_ex_alu),
                b_mem_valid, b_mem_rd, b_mem_wr, b_mem_br, b_mem_bne, b_mem_j,
                b_wb_valid, b_wb_rw, b_wb_m2r};
    endfunction

    task automatic step(input logic [31:0] ins, input bit st = 0, input bit fl = 0, input bit rs = 0);
        Instruction = ins; Stall = st; Flush = fl; Rst = rs;
        @(posedge Clk);
        cyc++;
        rst_m[cyc] = rs;
        if (rs || fl || st) ex_m[cyc] = bubble();
        else                ex_m[cyc] = decode(ins);
        if (rs || fl || cyc == 0) mem_m[cyc] = bubble();
        else                      mem_m[cyc] = ex_m[cyc-1];
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 5; i++) step(32'h0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(LW, 0, 0, 1);
            asserts++;
            if ({obs_a(), obs_b()} !== 44'h0) begin
                fails++; $display("FAIL reset_hold cyc %0d: got %h_%h want 0", i, obs_a(), obs_b());
            end
        end
        step(32'h0);
        asserts++;
        if ({obs_a(), obs_b()} !== 44'h0) begin
            fails++; $display("FAIL reset_release: got %h_%h want 0", obs_a(), obs_b());
        end
    endtask

    task automatic test_stream();
        logic [31:0] prog[8] = '{ADD, LW, SW, BEQ, 32'h0, 32'h0, 32'h0, 32'h0};
        int alu_seq[4] = '{0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            step(prog[i]);
            if (i < 4) begin
                asserts++;
                if (a_ex_alu !== 4'(alu_seq[i]) || b_ex_alu !== 6'(alu_seq[i])) begin
                    fails++; $display("FAIL stream_alu edge %0d: got %0d/%0d want %0d", i+1, a_ex_alu, b_ex_alu, alu_seq[i]);
                end
            end
            asserts++;
            if (a_mem_rd !== 1'(i + 1 == 3)) begin
                fails++; $display("FAIL stream_memread edge %0d: got %b want %b", i+1, a_mem_rd, i + 1 == 3);
            end
            asserts++;
            if (a_wb_m2r !== 1'(i + 1 == 4) || b_wb_m2r !== 1'(i + 1 == 6)) begin
                fails++; $display("FAIL stream_memtoreg edge %0d: got %b/%b want %b/%b", i+1, a_wb_m2r, b_wb_m2r, i + 1 == 4, i + 1 == 6);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] prog[7] = '{LW, SUB, SUB, 32'h0, 32'h0, 32'h0, 32'h0};
        bit st[7]  = '{0, 1, 0, 0, 0, 0, 0};
        bit exv[7] = '{1, 0, 1, 0, 0, 0, 0};
        bit arw[7] = '{0, 0, 1, 0, 1, 0, 0};
        bit brw[7] = '{0, 0, 0, 0, 1, 0, 1};
        drain();
        for (int i = 0; i < 7; i++) begin
            step(prog[i], st[i]);
            asserts++;
            if (a_ex_valid !== exv[i] || b_ex_valid !== exv[i]) begin
                fails++; $display("FAIL stall_exvalid edge %0d: got %b/%b want %b", i+1, a_ex_valid, b_ex_valid, exv[i]);
            end
            asserts++;
            if (a_wb_rw !== arw[i] || b_wb_rw !== brw[i]) begin
                fails++; $display("FAIL stall_regwrite edge %0d: got %b/%b want %b/%b", i+1, a_wb_rw, b_wb_rw, arw[i], brw[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] prog[7] = '{BNE, ADDI, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        bit fl[7] = '{0, 1, 0, 0, 0, 0, 0};
        drain();
        for (int i = 0; i < 7; i++) begin
            step(prog[i], 0, fl[i]);
            asserts++;
            if (a_ex_valid !== 1'(i == 0) || b_ex_valid !== 1'(i == 0) || a_mem_valid !== 1'b0 || b_mem_valid !== 1'b0) begin
                fails++; $display("FAIL flush_valid edge %0d: got ex %b/%b mem %b/%b want ex %b mem 0", i+1, a_ex_valid, b_ex_valid, a_mem_valid, b_mem_valid, i == 0);
            end
            asserts++;
            if (a_wb_rw !== 1'b0 || b_wb_rw !== 1'b0) begin
                fails++; $display("FAIL flush_regwrite edge %0d: got %b/%b want 0", i+1, a_wb_rw, b_wb_rw);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] prog[4] = '{ILL_OP, 32'h0, ILL_FN, 32'h0};
        bit ill[4] = '{1, 0, 1, 0};
        drain();
        for (int i = 0; i < 4; i++) begin
            step(prog[i]);
            asserts++;
            if (a_ex_ill !== ill[i] || b_ex_ill !== ill[i] || a_ex_valid !== 1'b0 || a_mem_valid !== 1'b0) begin
                fails++; $display("FAIL illegal edge %0d: got ill %b/%b exv %b memv %b want ill %b valid 0", i+1, a_ex_ill, b_ex_ill, a_ex_valid, a_mem_valid, ill[i]);
            end
        end
    endtask

    task automatic test_depth();
        bit arw[6] = '{0, 0, 1, 0, 0, 0};
        bit brw[6] = '{0, 0, 0, 0, 1, 0};
        drain();
        for (int i = 0; i < 6; i++) begin
            step(i == 0 ? JAL : 32'h0);
            if (i == 0) begin
                asserts++;
                if (b_ex_link !== 1'b1 || b_ex_alu !== 6'd0 || b_ex_valid !== 1'b1) begin
                    fails++; $display("FAIL depth_jal_ex: got link %b alu %0d valid %b want 1 0 1", b_ex_link, b_ex_alu, b_ex_valid);
                end
            end
            asserts++;
            if (a_wb_rw !== arw[i] || b_wb_rw !== brw[i]) begin
                fails++; $display("FAIL depth_regwrite edge %0d: got %b/%b want %b/%b", i+1, a_wb_rw, b_wb_rw, arw[i], brw[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] prog[3] = '{ADD, ADDI, LW};
        drain();
        for (int i = 0; i < 3; i++) step(prog[i]);
        step(ADD, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            asserts++;
            if (a_wb_rw !== 1'b0 || b_wb_rw !== 1'b0 || a_wb_valid !== 1'b0 || b_wb_valid !== 1'b0) begin
                fails++; $display("FAIL reset_mid edge %0d: got rw %b/%b valid %b/%b want 0", i, a_wb_rw, b_wb_rw, a_wb_valid, b_wb_valid);
            end
            step(32'h0);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops[14] = '{6'd0, 6'd0, 6'd0, 6'd28, 6'd8, 6'd12, 6'd13, 6'd10,
                                6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3};
        logic [5:0] fns[8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd2, 6'd33};
        logic [31:0] body = $urandom;
        int r = $urandom_range(0, 15);
        logic [5:0] op;
        if (r == 15) return 32'h0;
        op = (r == 14) ? 6'($urandom) : ops[r];
        if (op == 6'd0 || op == 6'd28) body[5:0] = fns[$urandom_range(0, 7)];
        return {op, body[25:0]};
    endfunction

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(rand_instr(), $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 39) == 0);
            asserts++;
            if (obs_a() !== model_vec(1)) begin
                fails++; $display("FAIL random_d1 cyc %0d: got %h want %h", cyc, obs_a(), model_vec(1));
            end
            asserts++;
            if (obs_b() !== model_vec(3)) begin
                fails++; $display("FAIL random_d3 cyc %0d: got %h want %h", cyc, obs_b(), model_vec(3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_illegal();
        test_depth();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/pipelined_controller.md
# pipelined_controller

Parametrised main control unit for the 5-stage MIPS pipeline. Decodes the ID-stage instruction into ALU, memory and write-back control fields. Carries those fields through registered ID/EX, EX/MEM and MEM/WB control stages with per-stage valid bits, so each pipeline stage reads its controls directly from this block. Supports hazard-unit stall and branch flush, and allows the memory path depth to vary by parameter.

## Interface
- ALUCTL_W, 4, width of ALUControl code; legal range 3..8.
- MEM_STAGES, 1, number of register stages between the EX/MEM and MEM/WB control outputs; legal range 1..4.
- Clk  in  1  clock; all state updates on the rising edge.
- Rst  in  1  reset: synchronous, active-high.
- Instruction  in  32  ID-stage instruction word.
- Stall  in  1  hazard stall; inserts a bubble into ID/EX.
- Flush  in  1  branch/jump flush; inserts bubbles into ID/EX and EX/MEM.
- EX_Valid, EX_ALUSrc, EX_RegDst, EX_Link  out  1 each  ID/EX control fields.
- EX_ALUControl  out  ALUCTL_W  ALU operation code.
- EX_Illegal  out  1  unsupported opcode/funct was decoded.
- MEM_Valid, MEM_MemRead, MEM_MemWrite, MEM_Branch, MEM_BranchNe, MEM_Jump  out  1 each  EX/MEM control fields.
- WB_Valid, WB_RegWrite, WB_MemToReg  out  1 each  MEM/WB control fields (end of the MEM chain).

## Operation
- Decode reads Instruction[31:26] (opcode) and Instruction[5:0] (funct) combinationally. The result is registered into the ID/EX stage.
- ALUControl codes (zero-extended to ALUCTL_W): ADD=0, SUB=1, AND=2, OR=3, SLT=4, SLL=5, MUL=6.
- R-type, opcode 000000; ALU op set by funct:
  - add 100000→ADD; sub 100010→SUB; and 100100→AND; or 100101→OR; slt 101010→SLT; sll 000000→SLL.
  - Controls: RegDst=1, RegWrite=1, ALUSrc=0.
- mul: opcode 011100, funct 000010 → MUL; RegDst=1, RegWrite=1.
- Immediate ALU ops: addi 001000→ADD, andi 001100→AND, ori 001101→OR, slti 001010→SLT. Controls: ALUSrc=1, RegWrite=1, RegDst=0.
- lw 100011: ADD, ALUSrc=1, MemRead=1, MemToReg=1, RegWrite=1.
- sw 101011: ADD, ALUSrc=1, MemWrite=1.
- beq 000100: SUB, Branch=1.
- bne 000101: SUB, Branch=1, BranchNe=1.
- j 000010: Jump=1.
- jal 000011: Jump=1, Link=1, RegWrite=1.
- Instruction 0x00000000 is a NOP. It decodes as a bubble: Valid=0, all controls 0, Illegal=0.
- Any other opcode/funct: bubble with EX_Illegal=1 for that slot. Illegal is not propagated past EX.
- Bubble: every control field 0, Valid=0, ALUControl=0.
- Per-edge priority, highest first:
  1. Rst: all stages cleared.
  2. Flush: ID/EX and EX/MEM load bubbles; MEM chain advances.
  3. Stall: ID/EX loads a bubble; EX/MEM and later advance.
  4. Otherwise all stages advance normally.
- Flush and Stall together behave as Flush.
- MEM chain: EX/MEM feeds MEM_STAGES-1 internal registers, then the MEM/WB register. MEM_* outputs come from EX/MEM. WB_* outputs come from MEM/WB.
- With MEM_STAGES=1 there are no internal registers.
- Only WB-relevant fields (RegWrite, MemToReg, Valid) are carried past EX/MEM.

## Timing
- Reset value of every output is 0, including all Valid bits and EX_Illegal.
- Cleared state is visible after the first rising edge with Rst=1.
- Latency, for an instruction presented in the cycle before edge k:
  - EX_* valid after edge k.
  - MEM_* valid after edge k+1.
  - WB_* valid after edge k+1+MEM_STAGES.
- Throughput: one instruction per cycle; no internal stall source.
- Stall at edge k: the Instruction value is dropped. The hazard unit holds IF/ID and re-presents the same word at edge k+1. One bubble appears on EX at edge k.
- Flush at edge k: the instruction currently on EX and the one entering are both squashed. MEM_Valid=0 after edge k, and EX_Valid=0 after edge k.
- Rst mid-stream: all in-flight slots are discarded in the same edge. No WB_RegWrite may appear afterward from pre-reset instructions.
- Outputs are registers only; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold Rst 2 cycles with Instruction=0x8C080004 (lw) → all outputs 0 throughout and on the first edge after release.
- Stream check, MEM_STAGES=1: present add (0x01095020), lw (0x8C080004), sw (0xAC080004), beq (0x11090002), one per cycle.
  - EX_ALUControl sequence 0,0,0,1.
  - MEM_MemRead pulses 1 on cycle 3.
  - WB_MemToReg=1 exactly 3 edges after lw was presented.
- Stall: present lw, then sub with Stall=1 for one cycle, then sub held → EX shows lw, bubble (EX_Valid=0), sub. WB_RegWrite pattern is 1,0,1.
- Flush: bne, then addi with Flush=1 on the addi edge → MEM_Valid=0 and EX_Valid=0 after that edge. No WB_RegWrite from either.
- Illegal: present opcode 111111 → EX_Illegal=1 for one cycle, EX_Valid=0, MEM_Valid=0 next cycle. Repeat with 0x00000000 → EX_Illegal=0.
- Depth: MEM_STAGES=3, ALUCTL_W=6, jal (0x0C000010) → EX_Link=1 and EX_ALUControl=6'd0. WB_RegWrite=1 appears 5 edges after presentation.
